// File: rtl/coolgirl_pkg.sv
// Shared mapper definitions: register-select encodings and common widths.
package coolgirl_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REG_SEL_W = 2;
  localparam int unsigned LOW_CNT_W = 3;

  typedef enum logic [REG_SEL_W-1:0] {
    REG_LATCH   = 2'd0,
    REG_RELOAD  = 2'd1,
    REG_DISABLE = 2'd2,
    REG_ENABLE  = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/mmc3_irq_counter_if.sv
// CPU register-write bus into the MMC3 IRQ block ($C000-$FFFF decoded).
interface mmc3_irq_counter_if;
  import coolgirl_pkg::*;

  logic                 reg_wr;
  logic [REG_SEL_W-1:0] reg_sel;
  logic [DATA_W-1:0]    reg_data;

  modport master (output reg_wr, reg_sel, reg_data);
  modport slave  (input  reg_wr, reg_sel, reg_data);
endinterface

// File: rtl/a12_filter.sv
// PPU A12 synchroniser and rising-edge qualifier; a rise counts only after
// A12 has been low for at least A12_LOW_MIN m2 cycles.
module a12_filter
  import coolgirl_pkg::*;
#(
  parameter int unsigned A12_LOW_MIN = 3
) (
  input  logic m2,
  input  logic rst_n,
  input  logic i_a12,
  output logic o_edge
);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic                 r_edge;
  logic [LOW_CNT_W-1:0] r_low_cnt;
  logic                 w_rise;
  logic                 w_long_low;

  assign w_rise     = r_sync2 & ~r_prev;
  assign w_long_low = (r_low_cnt >= LOW_CNT_W'(A12_LOW_MIN));

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_edge    <= 1'b0;
      r_low_cnt <= '0;
    end else begin
      r_sync1 <= i_a12;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= w_rise & w_long_low;
      // Saturating low-time count, measured on the synchronised signal
      if (r_sync2) begin
        r_low_cnt <= '0;
      end else if (r_low_cnt != '1) begin
        r_low_cnt <= r_low_cnt + LOW_CNT_W'(1);
      end
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/mmc3_irq_counter.sv
// MMC3 scanline IRQ counter: latch/reload/enable registers, A12-clocked
// down-counter and registered active-low IRQ output.
module mmc3_irq_counter
  import coolgirl_pkg::*;
#(
  parameter int unsigned A12_LOW_MIN = 3,
  parameter bit          ALT_IRQ     = 1'b0
) (
  input  logic               m2,
  input  logic               rst_n,
  input  logic               ppu_a12,
  mmc3_irq_counter_if.slave  bus,
  output logic               irq_n,
  output logic               a12_edge,
  output logic [DATA_W-1:0]  count
);

  logic [DATA_W-1:0] r_latch;
  logic [DATA_W-1:0] r_count;
  logic              r_reload;
  logic              r_enable;
  logic              r_pending;
  logic              r_irq_n;

  logic              w_edge;
  logic              w_wr_latch;
  logic              w_wr_reload;
  logic              w_wr_disable;
  logic              w_wr_enable;
  logic              w_reload_any;
  logic              w_en_eff;
  logic              w_set;
  logic [DATA_W-1:0] w_latch_nxt;
  logic [DATA_W-1:0] w_count_nxt;
  logic              w_reload_nxt;
  logic              w_enable_nxt;
  logic              w_pending_nxt;

  a12_filter #(
    .A12_LOW_MIN (A12_LOW_MIN)
  ) u_a12_filter (
    .m2     (m2),
    .rst_n  (rst_n),
    .i_a12  (ppu_a12),
    .o_edge (w_edge)
  );

  assign w_wr_latch   = bus.reg_wr && (bus.reg_sel == REG_LATCH);
  assign w_wr_reload  = bus.reg_wr && (bus.reg_sel == REG_RELOAD);
  assign w_wr_disable = bus.reg_wr && (bus.reg_sel == REG_DISABLE);
  assign w_wr_enable  = bus.reg_wr && (bus.reg_sel == REG_ENABLE);

  // A coincident reload write behaves as if the flag were already set; a
  // coincident disable beats any IRQ the edge would raise.
  assign w_reload_any = r_reload | w_wr_reload;
  assign w_en_eff     = (r_enable | w_wr_enable) & ~w_wr_disable;

  always_comb begin
    w_latch_nxt   = r_latch;
    w_count_nxt   = r_count;
    w_reload_nxt  = r_reload;
    w_enable_nxt  = r_enable;
    w_pending_nxt = r_pending;
    w_set         = 1'b0;

    if (w_wr_latch) begin
      w_latch_nxt = bus.reg_data;
    end

    if (w_edge) begin
      if ((r_count == '0) || w_reload_any) begin
        w_count_nxt  = r_latch;
        w_reload_nxt = 1'b0;
      end else begin
        w_count_nxt = r_count - DATA_W'(1);
      end
      w_set = (w_count_nxt == '0) && w_en_eff &&
              (!ALT_IRQ || (r_count != '0) || w_reload_any);
    end else if (w_wr_reload) begin
      w_count_nxt  = '0;
      w_reload_nxt = 1'b1;
    end

    if (w_wr_disable) begin
      w_enable_nxt = 1'b0;
    end else if (w_wr_enable) begin
      w_enable_nxt = 1'b1;
    end

    if (w_wr_disable) begin
      w_pending_nxt = 1'b0;
    end else if (w_set) begin
      w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      r_latch   <= '0;
      r_count   <= '0;
      r_reload  <= 1'b0;
      r_enable  <= 1'b0;
      r_pending <= 1'b0;
      r_irq_n   <= 1'b1;
    end else begin
      r_latch   <= w_latch_nxt;
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_enable  <= w_enable_nxt;
      r_pending <= w_pending_nxt;
      r_irq_n   <= ~w_pending_nxt;
    end
  end

  assign irq_n    = r_irq_n;
  assign a12_edge = w_edge;
  assign count    = r_count;

endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Directed bench: Sharp (u_dut0) and NEC (u_dut1) variants share all stimulus.
module tb_mmc3_irq_counter;
  import coolgirl_pkg::*;

  logic       m2;
  logic       rst_n;
  logic       ppu_a12;
  logic       irq_n0, irq_n1;
  logic       edge0, edge1;
  logic [7:0] count0, count1;

  int errors = 0;
  int checks = 0;

  logic edge_early, edge_at, edge_late, irq_at_edge;

  mmc3_irq_counter_if bus ();

  mmc3_irq_counter #(.A12_LOW_MIN(3), .ALT_IRQ(1'b0)) u_dut0 (
    .m2(m2), .rst_n(rst_n), .ppu_a12(ppu_a12), .bus(bus),
    .irq_n(irq_n0), .a12_edge(edge0), .count(count0)
  );

  mmc3_irq_counter #(.A12_LOW_MIN(3), .ALT_IRQ(1'b1)) u_dut1 (
    .m2(m2), .rst_n(rst_n), .ppu_a12(ppu_a12), .bus(bus),
    .irq_n(irq_n1), .a12_edge(edge1), .count(count1)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    bus.reg_wr   = 1'b1;
    bus.reg_sel  = sel;
    bus.reg_data = data;
    tick();
    bus.reg_wr   = 1'b0;
  endtask

  // A12 low for 'low' cycles then high; optional register write lands in the
  // cycle where a12_edge would be high.
  task automatic a12_pulse(input int low, input logic do_wr,
                           input logic [1:0] sel, input logic [7:0] data);
    ppu_a12 = 1'b0;
    repeat (low) tick();
    ppu_a12 = 1'b1;
    tick();
    tick();
    edge_early = edge0;
    tick();
    edge_at     = edge0;
    irq_at_edge = irq_n0;
    if (do_wr) begin
      bus.reg_wr   = 1'b1;
      bus.reg_sel  = sel;
      bus.reg_data = data;
    end
    tick();
    bus.reg_wr = 1'b0;
    edge_late  = edge0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    ppu_a12      = 1'b0;
    bus.reg_wr   = 1'b0;
    bus.reg_sel  = 2'd0;
    bus.reg_data = 8'd0;
    tick();
    checks++; if (irq_n0 !== 1'b1) begin errors++; $display("FAIL reset_irq_n0: got %b expected 1", irq_n0); end
    checks++; if (irq_n1 !== 1'b1) begin errors++; $display("FAIL reset_irq_n1: got %b expected 1", irq_n1); end
    checks++; if (edge0 !== 1'b0) begin errors++; $display("FAIL reset_edge: got %b expected 0", edge0); end
    checks++; if (count0 !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count0); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (irq_n0 !== 1'b1) begin errors++; $display("FAIL post_reset_irq_n: got %b expected 1", irq_n0); end
  endtask

  task automatic test_count();
    logic [7:0] exp_cnt [4];
    exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0};
    wr(REG_LATCH, 8'd3);
    wr(REG_RELOAD, 8'd0);
    checks++; if (count0 !== 8'd0) begin errors++; $display("FAIL reload_clears: got %0d expected 0", count0); end
    wr(REG_ENABLE, 8'd0);
    for (int i = 0; i < 4; i++) begin
      a12_pulse(4, 1'b0, REG_LATCH, 8'd0);
      checks++; if (edge_early !== 1'b0) begin errors++; $display("FAIL edge_latency_early[%0d]: got %b expected 0", i, edge_early); end
      checks++; if (edge_at !== 1'b1) begin errors++; $display("FAIL edge_pulse[%0d]: got %b expected 1", i, edge_at); end
      checks++; if (edge_late !== 1'b0) begin errors++; $display("FAIL edge_one_cycle[%0d]: got %b expected 0", i, edge_late); end
      checks++; if (count0 !== exp_cnt[i]) begin errors++; $display("FAIL count_seq[%0d]: got %0d expected %0d", i, count0, exp_cnt[i]); end
      checks++; if (irq_at_edge !== 1'b1) begin errors++; $display("FAIL irq_before_update[%0d]: got %b expected 1", i, irq_at_edge); end
      if (i == 3) begin
        checks++; if (irq_n0 !== 1'b0) begin errors++; $display("FAIL irq_at_zero_sharp: got %b expected 0", irq_n0); end
        checks++; if (irq_n1 !== 1'b0) begin errors++; $display("FAIL irq_at_zero_nec: got %b expected 0", irq_n1); end
      end else begin
        checks++; if (irq_n0 !== 1'b1) begin errors++; $display("FAIL irq_early[%0d]: got %b expected 1", i, irq_n0); end
      end
    end
  endtask

  task automatic test_ack();
    wr(REG_ENABLE, 8'd0);
    checks++; if (irq_n0 !== 1'b0) begin errors++; $display("FAIL enable_no_ack: got %b expected 0", irq_n0); end
    wr(REG_DISABLE, 8'd0);
    checks++; if (irq_n0 !== 1'b1) begin errors++; $display("FAIL disable_ack0: got %b expected 1", irq_n0); end
    checks++; if (irq_n1 !== 1'b1) begin errors++; $display("FAIL disable_ack1: got %b expected 1", irq_n1); end
  endtask

  task automatic test_filter();
    wr(REG_LATCH, 8'd5);
    wr(REG_RELOAD, 8'd0);
    a12_pulse(4, 1'b0, REG_LATCH, 8'd0);
    checks++; if (count0 !== 8'd5) begin errors++; $display("FAIL filter_setup: got %0d expected 5", count0); end
    a12_pulse(2, 1'b0, REG_LATCH, 8'd0);
    checks++; if (edge_at !== 1'b0) begin errors++; $display("FAIL short_low2_edge: got %b expected 0", edge_at); end
    checks++; if (count0 !== 8'd5) begin errors++; $display("FAIL short_low2_count: got %0d expected 5", count0); end
    a12_pulse(1, 1'b0, REG_LATCH, 8'd0);
    checks++; if (edge_at !== 1'b0) begin errors++; $display("FAIL short_low1_edge: got %b expected 0", edge_at); end
    a12_pulse(3, 1'b0, REG_LATCH, 8'd0);
    checks++; if (edge_at !== 1'b1) begin errors++; $display("FAIL min_low3_edge: got %b expected 1", edge_at); end
    checks++; if (count0 !== 8'd4) begin errors++; $display("FAIL min_low3_count: got %0d expected 4", count0); end
  endtask

  task automatic test_coincident();
    wr(REG_ENABLE, 8'd0);
    repeat (3) a12_pulse(4, 1'b0, REG_LATCH, 8'd0);
    checks++; if (count0 !== 8'd1) begin errors++; $display("FAIL coin_setup: got %0d expected 1", count0); end
    a12_pulse(4, 1'b1, REG_DISABLE, 8'd0);
    checks++; if (count0 !== 8'd0) begin errors++; $display("FAIL disable_edge_count: got %0d expected 0", count0); end
    checks++; if (irq_n0 !== 1'b1) begin errors++; $display("FAIL disable_edge_irq0: got %b expected 1", irq_n0); end
    checks++; if (irq_n1 !== 1'b1) begin errors++; $display("FAIL disable_edge_irq1: got %b expected 1", irq_n1); end
    tick();
    checks++; if (irq_n0 !== 1'b1) begin errors++; $display("FAIL disable_edge_hold: got %b expected 1", irq_n0); end

    wr(REG_LATCH, 8'd1);
    wr(REG_RELOAD, 8'd0);
    a12_pulse(4, 1'b1, REG_LATCH, 8'd2);
    checks++; if (count0 !== 8'd1) begin errors++; $display("FAIL latch_edge_old: got %0d expected 1", count0); end
    a12_pulse(4, 1'b1, REG_ENABLE, 8'd0);
    checks++; if (count0 !== 8'd0) begin errors++; $display("FAIL enable_edge_count: got %0d expected 0", count0); end
    checks++; if (irq_n0 !== 1'b0) begin errors++; $display("FAIL enable_edge_irq0: got %b expected 0", irq_n0); end
    checks++; if (irq_n1 !== 1'b0) begin errors++; $display("FAIL enable_edge_irq1: got %b expected 0", irq_n1); end
    wr(REG_DISABLE, 8'd0);
    a12_pulse(4, 1'b0, REG_LATCH, 8'd0);
    checks++; if (count0 !== 8'd2) begin errors++; $display("FAIL latch_edge_new: got %0d expected 2", count0); end
    a12_pulse(4, 1'b1, REG_RELOAD, 8'd0);
    checks++; if (count0 !== 8'd2) begin errors++; $display("FAIL reload_edge_load: got %0d expected 2", count0); end
    a12_pulse(4, 1'b0, REG_LATCH, 8'd0);
    checks++; if (count0 !== 8'd1) begin errors++; $display("FAIL reload_edge_flag_clr: got %0d expected 1", count0); end
  endtask

  task automatic test_alt();
    wr(REG_LATCH, 8'd0);
    wr(REG_RELOAD, 8'd0);
    wr(REG_ENABLE, 8'd0);
    a12_pulse(4, 1'b0, REG_LATCH, 8'd0);
    checks++; if (count0 !== 8'd0) begin errors++; $display("FAIL alt_count0: got %0d expected 0", count0); end
    checks++; if (count1 !== 8'd0) begin errors++; $display("FAIL alt_count1: got %0d expected 0", count1); end
    checks++; if (irq_n0 !== 1'b0) begin errors++; $display("FAIL alt_reload_irq0: got %b expected 0", irq_n0); end
    checks++; if (irq_n1 !== 1'b0) begin errors++; $display("FAIL alt_reload_irq1: got %b expected 0", irq_n1); end
    for (int i = 0; i < 2; i++) begin
      wr(REG_DISABLE, 8'd0);
      wr(REG_ENABLE, 8'd0);
      a12_pulse(4, 1'b0, REG_LATCH, 8'd0);
      checks++; if (irq_n0 !== 1'b0) begin errors++; $display("FAIL alt_repeat_irq0[%0d]: got %b expected 0", i, irq_n0); end
      checks++; if (irq_n1 !== 1'b1) begin errors++; $display("FAIL alt_repeat_irq1[%0d]: got %b expected 1", i, irq_n1); end
    end
    wr(REG_DISABLE, 8'd0);
    wr(REG_RELOAD, 8'd0);
    wr(REG_ENABLE, 8'd0);
    a12_pulse(4, 1'b0, REG_LATCH, 8'd0);
    checks++; if (irq_n1 !== 1'b0) begin errors++; $display("FAIL alt_rereload_irq1: got %b expected 0", irq_n1); end
    wr(REG_DISABLE, 8'd0);
  endtask

  task automatic test_reset_mid();
    wr(REG_LATCH, 8'd3);
    wr(REG_RELOAD, 8'd0);
    wr(REG_ENABLE, 8'd0);
    repeat (5) a12_pulse(4, 1'b0, REG_LATCH, 8'd0);
    checks++; if (count0 !== 8'd3) begin errors++; $display("FAIL mid_setup_count: got %0d expected 3", count0); end
    checks++; if (irq_n0 !== 1'b0) begin errors++; $display("FAIL mid_setup_irq: got %b expected 0", irq_n0); end
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (irq_n0 !== 1'b1) begin errors++; $display("FAIL async_rst_irq0: got %b expected 1", irq_n0); end
    checks++; if (irq_n1 !== 1'b1) begin errors++; $display("FAIL async_rst_irq1: got %b expected 1", irq_n1); end
    checks++; if (count0 !== 8'd0) begin errors++; $display("FAIL async_rst_count: got %0d expected 0", count0); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (edge0 !== 1'b0) begin errors++; $display("FAIL post_rst_no_edge: got %b expected 0", edge0); end
    a12_pulse(2, 1'b0, REG_LATCH, 8'd0);
    checks++; if (edge_at !== 1'b0) begin errors++; $display("FAIL post_rst_low2: got %b expected 0", edge_at); end
    a12_pulse(3, 1'b0, REG_LATCH, 8'd0);
    checks++; if (edge_at !== 1'b1) begin errors++; $display("FAIL post_rst_low3: got %b expected 1", edge_at); end
    checks++; if (irq_n0 !== 1'b1) begin errors++; $display("FAIL post_rst_irq: got %b expected 1", irq_n0); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_ack();
    test_filter();
    test_coincident();
    test_alt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmc3_irq_counter.md
MMC3_IRQ_COUNTER -- requirements
Module: mmc3_irq_counter

Interface
REQ-001 SHALL have parameter A12_LOW_MIN, default 3, the number of M2 cycles A12 must be low before a rising edge qualifies (range 1..7).
REQ-002 SHALL have parameter ALT_IRQ, default 0: 0 selects Sharp behaviour (IRQ whenever the count is 0 after a clock); 1 selects NEC behaviour (IRQ only on a transition to 0 or an explicit reload to 0).
REQ-003 SHALL have m2  input  1  CPU M2, the single clock; all state changes on posedge m2.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ppu_a12  input  1  raw PPU A12, asynchronous to m2.
REQ-006 SHALL have reg_wr  input  1  one-cycle write strobe, already decoded for the $C000-$FFFF odd/even registers.
REQ-007 SHALL have reg_sel  input  2  register select: 0 = latch ($C000), 1 = reload ($C001), 2 = disable ($E000), 3 = enable ($E001).
REQ-008 SHALL have reg_data  input  8  CPU write data.
REQ-009 SHALL have irq_n  output  1  active-low IRQ request to the top-level irq pin.
REQ-010 SHALL have a12_edge  output  1  one-cycle pulse per qualified A12 rise, for reuse by other mapper logic.
REQ-011 SHALL have count  output  8  current counter value, for debug.

Function
REQ-012 SHALL synchronise ppu_a12 through two m2 flops before any use.
REQ-013 SHALL keep a 3-bit saturating low-time counter: it clears while synchronised A12 is high and increments while A12 is low, stopping at 7.
REQ-014 SHALL pulse a12_edge for exactly one cycle when synchronised A12 goes 0->1 and the low-time counter is >= A12_LOW_MIN; other rises are ignored.
REQ-015 SHALL, on a latch write, store reg_data into the 8-bit latch.
REQ-016 SHALL, on a reload write, set reload_flag and clear count to 0.
REQ-017 SHALL, on a disable write, clear irq_enable and clear any pending IRQ.
REQ-018 SHALL, on an enable write, set irq_enable and leave any pending IRQ unchanged.
REQ-019 SHALL, on a12_edge, load count from the latch if count==0 or reload_flag==1 (then clear reload_flag); otherwise decrement count by 1, with no wrap below 0.
REQ-020 SHALL, on a12_edge with the resulting count==0 and irq_enable==1, set pending: unconditionally when ALT_IRQ=0; when ALT_IRQ=1, only if the previous count!=0 or reload_flag was set.
REQ-021 SHALL drive irq_n = ~pending, registered, with no combinational path from inputs.
REQ-022 SHALL hold pending until a disable write; an enable write does not acknowledge it.
REQ-023 SHALL handle a latch write coincident with a12_edge as follows: the edge uses the old latch value, and the new value is stored for later edges.
REQ-024 SHALL handle a reload write coincident with a12_edge by loading count from the new reload state (latch value) and leaving reload_flag cleared.
REQ-025 SHALL handle a disable write coincident with an edge that would set pending as follows: disable wins (pending=0), and the count still updates.
REQ-026 SHALL handle an enable write coincident with such an edge by setting pending.
REQ-027 SHALL have a latency of 1 m2 cycle from a12_edge to the irq_n change, and 3 m2 cycles from the raw A12 rise to a12_edge.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force latch=0, count=0, reload_flag=0, irq_enable=0, pending=0, irq_n=1, a12_edge=0, synchroniser flops=0, and low-time counter=0.
REQ-029 SHALL, on reset asserted mid-operation, abort any pending IRQ immediately, with no glitch low on irq_n.
REQ-030 SHALL require a full A12_LOW_MIN low interval after reset release before the first edge can qualify.

Structure
REQ-031 SHALL take the reg_sel encodings (REG_LATCH, REG_RELOAD, REG_DISABLE, REG_ENABLE) from the shared coolgirl_pkg package.
REQ-032 SHALL implement the synchroniser, low-time counter and edge qualifier as one sub-module, a12_filter, which other mappers (#004/#118/#189) also reuse.

Verification
REQ-033 SHALL verify: latch=3, reload, enable, then 4 qualified A12 rises -> count 3,2,1,0, and irq_n falls 1 cycle after the 4th a12_edge.
REQ-034 SHALL verify: A12 pulses preceded by only 2 low cycles (A12_LOW_MIN=3) -> no a12_edge, and count unchanged.
REQ-035 SHALL verify: latch=0, enable, edges -> ALT_IRQ=0 gives IRQ on every edge; ALT_IRQ=1 gives IRQ only on the edge after a reload write.
REQ-036 SHALL verify: pending IRQ, then enable write -> irq_n stays 0; then disable write -> irq_n=1 next cycle.
REQ-037 SHALL verify: disable write in the same cycle as an edge reaching 0 -> irq_n stays 1 and count=0.
REQ-038 SHALL verify: rst_n pulsed low mid-count with irq_n=0 -> irq_n=1 and count=0 asynchronously, and the first edge after release requires 3 low cycles.
